shadowmask_loader: RTL

SHADOWMASK_LOADER -- requirements
Module: shadowmask_loader

---
 rtl/shadowmask_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/shadowmask_loader.sv
// Shadow-mask loader: streams a header, the pattern size and the mask lookup table as command words.
// Define SHADOWMASK_LOADER_ABORT_EN to add the abort input and its mask-disable epilogue.
module shadowmask_loader #(
   parameter int unsigned GAP = 0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        mask_wr,
   input  logic [7:0]  mask_addr,
   input  logic [10:0] mask_data,
   input  logic        cfg_enable,
   input  logic        cfg_rotate,
   input  logic        cfg_2x,
   input  logic [3:0]  cfg_hmax,
   input  logic [3:0]  cfg_vmax,
   input  logic        start,
`ifdef SHADOWMASK_LOADER_ABORT_EN
   input  logic        abort,
`endif
   output logic        cmd_wr,
   output logic [15:0] cmd_in,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_VMAX = 3'd2;
   localparam logic [2:0] S_HMAX = 3'd3;
   localparam logic [2:0] S_LUT  = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;
   localparam logic [2:0] S_ABT  = 3'd6;

   localparam logic [3:0] GAP_LOAD = 4'(GAP);

   logic [10:0] mask_mem [256];

   logic [2:0]  state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [3:0]  gap_q, gap_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [15:0] cmd_in_q, cmd_in_d;
   logic        en_q, en_d;
   logic        rot_q, rot_d;
   logic        x2_q, x2_d;
   logic [3:0]  hmax_q, hmax_d;
   logic [3:0]  vmax_q, vmax_d;
   logic [7:0]  last_addr;
   logic [7:0]  next_addr;
   logic        active;
   logic        last_word;
   logic        abort_hit;

   always_ff @(posedge clk_sys) begin
      if (mask_wr) begin
         mask_mem[mask_addr] <= mask_data;
      end
   end

   assign last_addr = {vmax_q, 4'hF};
   assign next_addr = addr_q + 8'd1;
   assign active    = (state_q != S_IDLE) && (state_q != S_FIN);
   assign last_word = (state_q == S_ABT) || ((state_q == S_LUT) && (addr_q == last_addr));

`ifdef SHADOWMASK_LOADER_ABORT_EN
   // An abort may arrive during a gap, so it is held until the next command slot.
   logic abort_pend_q, abort_pend_d;

   assign abort_hit = (abort_pend_q || abort) && active && (state_q != S_ABT);

   always_comb begin
      abort_pend_d = abort_pend_q;
      if (abort && active && (state_q != S_ABT)) begin
         abort_pend_d = 1'b1;
      end
      if ((state_d == S_ABT) || !active) begin
         abort_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         abort_pend_q <= 1'b0;
      end else begin
         abort_pend_q <= abort_pend_d;
      end
   end
`else
   assign abort_hit = 1'b0;
`endif

   // The table is read one cycle ahead of each word, so LUT words stream without bubbles.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      gap_d    = gap_q;
      cmd_wr_d = 1'b0;
      cmd_in_d = 16'h0000;
      en_d     = en_q;
      rot_d    = rot_q;
      x2_d     = x2_q;
      hmax_d   = hmax_q;
      vmax_d   = vmax_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               en_d     = cfg_enable;
               rot_d    = cfg_rotate;
               x2_d     = cfg_2x;
               hmax_d   = cfg_hmax;
               vmax_d   = cfg_vmax;
               addr_d   = 8'd0;
               gap_d    = GAP_LOAD;
               state_d  = S_HDR;
               cmd_wr_d = 1'b1;
               cmd_in_d = {12'h000, cfg_enable, cfg_rotate, cfg_2x, 1'b0};
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         S_HDR, S_VMAX, S_HMAX, S_LUT, S_ABT: begin
            if (cmd_wr_q && last_word && !abort_hit) begin
               state_d = S_FIN;
               gap_d   = 4'd0;
            end else if (gap_q != 4'd0) begin
               gap_d = gap_q - 4'd1;
            end else begin
               cmd_wr_d = 1'b1;
               gap_d    = GAP_LOAD;
               if (abort_hit) begin
                  state_d  = S_ABT;
                  cmd_in_d = 16'h0000;
               end else begin
                  case (state_q)
                     S_HDR: begin
                        state_d  = S_VMAX;
                        cmd_in_d = {12'h200, vmax_q};
                     end
                     S_VMAX: begin
                        state_d  = S_HMAX;
                        cmd_in_d = {12'h400, hmax_q};
                     end
                     S_HMAX: begin
                        state_d  = S_LUT;
                        addr_d   = 8'd0;
                        cmd_in_d = {5'b01100, mask_mem[8'd0]};
                     end
                     default: begin
                        addr_d   = next_addr;
                        cmd_in_d = {5'b01100, mask_mem[next_addr]};
                     end
                  endcase
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= 8'd0;
         gap_q    <= 4'd0;
         cmd_wr_q <= 1'b0;
         cmd_in_q <= 16'h0000;
         en_q     <= 1'b0;
         rot_q    <= 1'b0;
         x2_q     <= 1'b0;
         hmax_q   <= 4'd0;
         vmax_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         gap_q    <= gap_d;
         cmd_wr_q <= cmd_wr_d;
         cmd_in_q <= cmd_in_d;
         en_q     <= en_d;
         rot_q    <= rot_d;
         x2_q     <= x2_d;
         hmax_q   <= hmax_d;
         vmax_q   <= vmax_d;
      end
   end

   assign cmd_wr = cmd_wr_q;
   assign cmd_in = cmd_in_q;
   assign busy   = active;
   assign done   = (state_q == S_FIN);

endmodule
